serial_in_parallel_out: RTL

Deserializer that assembles a serial bitstream into WIDTH-bit words and presents each completed word on a held parallel bus with a valid/ready handshake. It sits directly upstream of the parallel-in/parallel-out register bank: its `parallel_out` drives that bank's `parallel_in`. A sticky overflow flag reports words lost to downstream backpressure.

---
 rtl/serial_in_parallel_out.sv | 84 ++++++++
 1 files changed

// File: rtl/serial_in_parallel_out.sv
// Serial-to-parallel deserializer: collects WIDTH serial bits into a word and
// presents it on a held parallel bus with a valid/ready handshake and sticky overflow.
module serial_in_parallel_out #(
  parameter int WIDTH     = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     serial_in,
  input  logic                     serial_valid,
  input  logic                     frame_start,
  output logic [WIDTH-1:0]         parallel_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic [$clog2(WIDTH)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_p0;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] word_p0;
  logic [CW-1:0]    count_next;
  logic             complete_p0;
  logic             take_p0;

  function automatic logic [WIDTH-1:0] insert_bit(input logic [WIDTH-1:0] base,
                                                  input logic b);
    if (MSB_FIRST) return {base[WIDTH-2:0], b};
    else           return {b, base[WIDTH-1:1]};
  endfunction

  // Collection stage: next shift state, counter and completion detect.
  always_comb begin
    shreg_next  = shreg_p0;
    count_next  = bit_count;
    complete_p0 = 1'b0;
    word_p0     = insert_bit(shreg_p0, serial_in);
    if (serial_valid) begin
      if (frame_start) begin
        shreg_next = insert_bit('0, serial_in);
        count_next = CW'(1);
      end else if (bit_count == LAST_IDX) begin
        complete_p0 = 1'b1;
        shreg_next  = word_p0;
        count_next  = '0;
      end else begin
        shreg_next = word_p0;
        count_next = bit_count + CW'(1);
      end
    end else if (frame_start) begin
      shreg_next = '0;
      count_next = '0;
    end
  end

  // A completed word is only accepted if the output slot is free or draining now.
  assign take_p0 = complete_p0 && (!out_valid || out_ready);

  // Output stage: held word, valid flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_p0     <= '0;
      bit_count    <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      shreg_p0  <= shreg_next;
      bit_count <= count_next;
      if (take_p0) begin
        parallel_out <= word_p0;
        out_valid    <= 1'b1;
      end else if (complete_p0) begin
        overflow <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
